fdct_seq: RTL and testbench

FDCT_SEQ -- requirements
Module: fdct_seq

---
 rtl/fdct_pkg.sv | 17 +
 rtl/fdct_vdelay.sv | 40 ++++
 rtl/fdct_seq.sv | 157 +++++++++++++++
 tb/tb_fdct_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fdct_pkg.sv
// Shared defaults and FSM state type for the 2-D DCT row/column sequencer.
package fdct_pkg;

    localparam int N_DEF     = 8;
    localparam int LAT_DEF   = 4;
    localparam int IDX_W_DEF = $clog2(N_DEF);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROW_ISSUE = 3'd1,
        ST_ROW_DRAIN = 3'd2,
        ST_COL_ISSUE = 3'd3,
        ST_COL_DRAIN = 3'd4,
        ST_DONE      = 3'd5
    } fdct_state_t;

endpackage

// File: rtl/fdct_vdelay.sv
// LAT-deep {valid, index} shift register that tracks issues through the DCT core pipeline.
module fdct_vdelay #(
    parameter int LAT   = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    logic [LAT-1:0]   valid_q;
    logic [IDX_W-1:0] idx_q [LAT];

    // Shift stage 0 -> LAT-1 while enabled; idle slots carry a zero index.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= IDX_ZERO;
            end
        end else if (en_i) begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= valid_i ? idx_i : IDX_ZERO;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign idx_o   = idx_q[LAT-1];

endmodule

// File: rtl/fdct_seq.sv
// Row/column pass sequencer for a pipelined 1-D DCT core computing an NxN 2-D transform.
// Optional FDCT_SEQ_HOLD_EN adds a 'hold' input that freezes the whole sequencer.
module fdct_seq
    import fdct_pkg::*;
#(
    parameter  int LAT   = LAT_DEF,
    parameter  int N     = N_DEF,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FDCT_SEQ_HOLD_EN
    input  logic             hold,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             in_rd_en,
    output logic [IDX_W-1:0] in_rd_row,
    output logic             tb_wr_en,
    output logic [IDX_W-1:0] tb_wr_row,
    output logic             tb_rd_en,
    output logic [IDX_W-1:0] tb_rd_col,
    output logic             out_wr_en,
    output logic [IDX_W-1:0] out_wr_idx,
    output logic             core_pass,
    output logic             core_en
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    fdct_state_t      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             run_s;
    logic             row_vld_s, col_vld_s;
    logic [IDX_W-1:0] row_idx_s, col_idx_s;

`ifdef FDCT_SEQ_HOLD_EN
    assign run_s = ~hold;
`else
    assign run_s = 1'b1;
`endif

    // State and issue counter; hold freezes both, reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= IDX_ZERO;
        end else if (run_s) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: issue phases are counter-bounded, drain phases wait for the last index to emerge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ROW_ISSUE;
                    cnt_d   = IDX_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROW_ISSUE: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_ROW_DRAIN;
                    cnt_d   = IDX_ZERO;
                end else begin
                    cnt_d = cnt_q + IDX_ONE;
                end
            end
            ST_ROW_DRAIN: begin
                if (row_vld_s && (row_idx_s == LAST_IDX)) begin
                    state_d = ST_COL_ISSUE;
                    cnt_d   = IDX_ZERO;
                end else begin
                    state_d = ST_ROW_DRAIN;
                end
            end
            ST_COL_ISSUE: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_COL_DRAIN;
                    cnt_d   = IDX_ZERO;
                end else begin
                    cnt_d = cnt_q + IDX_ONE;
                end
            end
            ST_COL_DRAIN: begin
                if (col_vld_s && (col_idx_s == LAST_IDX)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COL_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = IDX_ZERO;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = IDX_ZERO;
            end
        endcase
    end

    // Output decode from registered state; every strobe is suppressed while held.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        core_pass = (state_q == ST_COL_ISSUE) || (state_q == ST_COL_DRAIN);
        core_en   = run_s;
        in_rd_en  = 1'b0;
        tb_wr_en  = 1'b0;
        tb_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        done      = 1'b0;
        if (run_s) begin
            in_rd_en  = (state_q == ST_ROW_ISSUE);
            tb_rd_en  = (state_q == ST_COL_ISSUE);
            tb_wr_en  = row_vld_s;
            out_wr_en = col_vld_s;
            done      = (state_q == ST_DONE);
        end else begin
            done = 1'b0;
        end
        in_rd_row  = in_rd_en  ? cnt_q     : IDX_ZERO;
        tb_rd_col  = tb_rd_en  ? cnt_q     : IDX_ZERO;
        tb_wr_row  = tb_wr_en  ? row_idx_s : IDX_ZERO;
        out_wr_idx = out_wr_en ? col_idx_s : IDX_ZERO;
    end

    fdct_vdelay #(.LAT(LAT), .IDX_W(IDX_W)) u_row_dly (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (run_s),
        .valid_i (in_rd_en),
        .idx_i   (cnt_q),
        .valid_o (row_vld_s),
        .idx_o   (row_idx_s)
    );

    fdct_vdelay #(.LAT(LAT), .IDX_W(IDX_W)) u_col_dly (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (run_s),
        .valid_i (tb_rd_en),
        .idx_i   (cnt_q),
        .valid_o (col_vld_s),
        .idx_o   (col_idx_s)
    );

endmodule

// File: tb/tb_fdct_seq.sv
// Self-checking bench for fdct_seq: default (N=8, LAT=4) and small (N=4, LAT=1) instances.
module tb_fdct_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start0, start1;
`ifdef FDCT_SEQ_HOLD_EN
    logic hold;
`endif

    logic       d_busy, d_done, d_in_en, d_tbw_en, d_tbr_en, d_out_en, d_pass, d_cen;
    logic [2:0] d_in_row, d_tbw_row, d_tbr_col, d_out_idx;
    logic       s_busy, s_done, s_in_en, s_tbw_en, s_tbr_en, s_out_en, s_pass, s_cen;
    logic [1:0] s_in_row, s_tbw_row, s_tbr_col, s_out_idx;

    fdct_seq u_def (
        .clk(clk), .reset(reset),
`ifdef FDCT_SEQ_HOLD_EN
        .hold(hold),
`endif
        .start(start0), .busy(d_busy), .done(d_done),
        .in_rd_en(d_in_en), .in_rd_row(d_in_row),
        .tb_wr_en(d_tbw_en), .tb_wr_row(d_tbw_row),
        .tb_rd_en(d_tbr_en), .tb_rd_col(d_tbr_col),
        .out_wr_en(d_out_en), .out_wr_idx(d_out_idx),
        .core_pass(d_pass), .core_en(d_cen)
    );

    fdct_seq #(.LAT(1), .N(4)) u_small (
        .clk(clk), .reset(reset),
`ifdef FDCT_SEQ_HOLD_EN
        .hold(1'b0),
`endif
        .start(start1), .busy(s_busy), .done(s_done),
        .in_rd_en(s_in_en), .in_rd_row(s_in_row),
        .tb_wr_en(s_tbw_en), .tb_wr_row(s_tbw_row),
        .tb_rd_en(s_tbr_en), .tb_rd_col(s_tbr_col),
        .out_wr_en(s_out_en), .out_wr_idx(s_out_idx),
        .core_pass(s_pass), .core_en(s_cen)
    );

    typedef struct {
        int first;
        int last;
    } phase_t;

    // Phase order: in_rd, tb_wr, tb_rd, out_wr, done, busy (cycles relative to the start cycle)
    phase_t tbl_def[6];
    phase_t tbl_small[6];
    string  pname[6];

    int n_cmp = 0;
    int n_err = 0;
    int rel   = 0;
    int en_a[6];
    int idx_a[4];
    int pass_v, cen_v;
    int done_t[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s rel=%0d: got %0d, want %0d", nm, rel, act, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            en_a[0] = int'(d_in_en);  idx_a[0] = int'(d_in_row);
            en_a[1] = int'(d_tbw_en); idx_a[1] = int'(d_tbw_row);
            en_a[2] = int'(d_tbr_en); idx_a[2] = int'(d_tbr_col);
            en_a[3] = int'(d_out_en); idx_a[3] = int'(d_out_idx);
            en_a[4] = int'(d_done);   en_a[5] = int'(d_busy);
            pass_v  = int'(d_pass);   cen_v   = int'(d_cen);
        end else begin
            en_a[0] = int'(s_in_en);  idx_a[0] = int'(s_in_row);
            en_a[1] = int'(s_tbw_en); idx_a[1] = int'(s_tbw_row);
            en_a[2] = int'(s_tbr_en); idx_a[2] = int'(s_tbr_col);
            en_a[3] = int'(s_out_en); idx_a[3] = int'(s_out_idx);
            en_a[4] = int'(s_done);   en_a[5] = int'(s_busy);
            pass_v  = int'(s_pass);   cen_v   = int'(s_cen);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One block from IDLE, checked every cycle against the phase table; optional hold window and start spam.
    task automatic run_block(input int sel, input int hs, input int he, input int ncyc, input bit spam);
        int  cnt[6];
        int  eff, first, last, nexp, exp_en;
        bit  held, st;
        nexp = (sel == 0) ? 8 : 4;
        for (int p = 0; p < 6; p++) cnt[p] = 0;
        for (int r = 0; r <= ncyc; r++) begin
            if (r > 0) step();
            held = (hs >= 0) && (r >= hs) && (r <= he);
`ifdef FDCT_SEQ_HOLD_EN
            hold = held;
`endif
            st = (r == 0) || (spam && (r == 3 || r == 12 || r == 20 || r == 25));
            if (sel == 0) start0 = st; else start1 = st;
            #1;
            rel = r;
            sample(sel);
            eff = (he >= 0 && r > he) ? r - (he - hs + 1) : r;
            for (int p = 0; p < 6; p++) begin
                first  = (sel == 0) ? tbl_def[p].first : tbl_small[p].first;
                last   = (sel == 0) ? tbl_def[p].last  : tbl_small[p].last;
                exp_en = held ? int'(p == 5) : int'(eff >= first && eff <= last);
                chk(pname[p], en_a[p], exp_en);
                cnt[p] += en_a[p];
                if (p < 4) chk({pname[p], "_idx"}, idx_a[p], (exp_en == 1 && !held) ? eff - first : 0);
                if (!held && exp_en == 1 && p == 0) chk("core_pass_row", pass_v, 0);
                if (!held && exp_en == 1 && p == 2) chk("core_pass_col", pass_v, 1);
            end
            chk("core_en", cen_v, held ? 0 : 1);
        end
        start0 = 1'b0;
        start1 = 1'b0;
`ifdef FDCT_SEQ_HOLD_EN
        hold = 1'b0;
`endif
        for (int p = 0; p < 4; p++) chk({pname[p], "_count"}, cnt[p], nexp);
        chk("done_count", cnt[4], 1);
    endtask

    initial begin
        int acc;
        tbl_def[0] = '{first: 1,  last: 8};
        tbl_def[1] = '{first: 5,  last: 12};
        tbl_def[2] = '{first: 13, last: 20};
        tbl_def[3] = '{first: 17, last: 24};
        tbl_def[4] = '{first: 25, last: 25};
        tbl_def[5] = '{first: 1,  last: 25};
        tbl_small[0] = '{first: 1,  last: 4};
        tbl_small[1] = '{first: 2,  last: 5};
        tbl_small[2] = '{first: 6,  last: 9};
        tbl_small[3] = '{first: 7,  last: 10};
        tbl_small[4] = '{first: 11, last: 11};
        tbl_small[5] = '{first: 1,  last: 11};
        pname = '{"in_rd_en", "tb_wr_en", "tb_rd_en", "out_wr_en", "done", "busy"};

        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
`ifdef FDCT_SEQ_HOLD_EN
        hold = 1'b0;
`endif
        repeat (3) step();
        rel = 0;
        for (int s = 0; s < 2; s++) begin
            sample(s);
            for (int p = 0; p < 6; p++) chk({"reset_", pname[p]}, en_a[p], 0);
            for (int p = 0; p < 4; p++) chk({"reset_", pname[p], "_idx"}, idx_a[p], 0);
            chk("reset_core_pass", pass_v, 0);
        end
        reset = 1'b0;
        step();

        run_block(0, -1, -1, 27, 1'b0);
        run_block(1, -1, -1, 13, 1'b0);

        // Start pulses while busy and in DONE are ignored; nothing follows the single block.
        run_block(0, -1, -1, 27, 1'b1);
        acc = 0;
        for (int r = 0; r < 20; r++) begin
            step();
            sample(0);
            acc += en_a[0] + en_a[4] + en_a[5];
        end
        chk("spam_no_rerun", acc, 0);

        // Start held high: back-to-back blocks, done every 26 cycles.
        done_t.delete();
        start0 = 1'b1;
        for (int r = 1; r <= 80; r++) begin
            step();
            rel = r;
            sample(0);
            if (en_a[4] == 1) done_t.push_back(r);
            if (r == 26) chk("cont_idle_gap_busy", en_a[5], 0);
            if (r == 27) chk("cont_restart_in_rd", en_a[0], 1);
        end
        start0 = 1'b0;
        chk("cont_done_count", done_t.size(), 3);
        for (int i = 0; i < 3; i++) chk("cont_done_time", (i < done_t.size()) ? done_t[i] : -1, 25 + 26 * i);
        repeat (26) step();
        sample(0);
        chk("cont_final_idle", en_a[5], 0);

        // Reset during COL_ISSUE, with start asserted at the same time.
        start0 = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            step();
            start0 = 1'b0;
        end
        rel = 15;
        sample(0);
        chk("pre_reset_tb_rd", en_a[2], 1);
        chk("pre_reset_tb_rd_col", idx_a[2], 2);
        reset  = 1'b1;
        start0 = 1'b1;
        step();
        rel = 16;
        reset  = 1'b0;
        start0 = 1'b0;
        #1;
        sample(0);
        for (int p = 0; p < 6; p++) chk({"midreset_", pname[p]}, en_a[p], 0);
        chk("midreset_core_pass", pass_v, 0);
        acc = 0;
        for (int r = 0; r < 30; r++) begin
            step();
            sample(0);
            for (int p = 0; p < 6; p++) acc += en_a[p];
        end
        chk("post_reset_quiet", acc, 0);
        run_block(0, -1, -1, 27, 1'b0);

`ifdef FDCT_SEQ_HOLD_EN
        // Hold for 3 cycles in ROW_DRAIN: everything shifts by 3, done at 28.
        run_block(0, 10, 12, 30, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
